// File: rtl/de_pipe_reg.sv
// Decode-to-Execute pipeline register: captures Decode-stage values, holds on stall,
// or loads a nop bubble on clr. The address and shamt fields are wired straight from E_instr.
module de_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_rsData,
    input  logic [31:0] D_rtData,
    input  logic [31:0] D_imm,
    input  logic        D_valid,
    output logic [31:0] E_instr,
    output logic [31:0] E_pc,
    output logic [31:0] E_rsData,
    output logic [31:0] E_rtData,
    output logic [31:0] E_imm,
    output logic [4:0]  E_rsAddr,
    output logic [4:0]  E_rtAddr,
    output logic [4:0]  E_rdAddr,
    output logic [4:0]  E_shamt,
    output logic        E_valid,
    output logic [15:0] E_bubbleCnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // A bubble keeps D_pc so the stalled instruction stays traceable in Execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_instr     <= 32'd0;
            E_pc        <= RESET_PC;
            E_rsData    <= 32'd0;
            E_rtData    <= 32'd0;
            E_imm       <= 32'd0;
            E_valid     <= 1'b0;
            E_bubbleCnt <= 16'd0;
        end else if (clr) begin
            E_instr  <= 32'd0;
            E_pc     <= D_pc;
            E_rsData <= 32'd0;
            E_rtData <= 32'd0;
            E_imm    <= 32'd0;
            E_valid  <= 1'b0;
            if (E_bubbleCnt != CNT_MAX) begin
                E_bubbleCnt <= E_bubbleCnt + 16'd1;
            end
        end else if (en) begin
            E_instr  <= D_instr;
            E_pc     <= D_pc;
            E_rsData <= D_rsData;
            E_rtData <= D_rtData;
            E_imm    <= D_imm;
            E_valid  <= D_valid;
        end
    end

    assign E_rsAddr = E_instr[25:21];
    assign E_rtAddr = E_instr[20:16];
    assign E_rdAddr = E_instr[15:11];
    assign E_shamt  = E_instr[10:6];

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: every driven edge pushes the expected E-side state to a queue,
// and each test pops that entry and compares it with the DUT after the edge.
module tb_de_pipe_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic        valid;
        logic [15:0] cnt;
        logic [4:0]  rsAddr;
        logic [4:0]  rtAddr;
        logic [4:0]  rdAddr;
        logic [4:0]  shamt;
    } expT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] D_instr = '0;
    logic [31:0] D_pc = '0;
    logic [31:0] D_rsData = '0;
    logic [31:0] D_rtData = '0;
    logic [31:0] D_imm = '0;
    logic        D_valid = 1'b0;
    logic [31:0] E_instr, E_pc, E_rsData, E_rtData, E_imm;
    logic [4:0]  E_rsAddr, E_rtAddr, E_rdAddr, E_shamt;
    logic        E_valid;
    logic [15:0] E_bubbleCnt;

    int checks = 0;
    int failures = 0;
    expT sbQ[$];
    expT mdl;
    expT got;
    expT exp;

    de_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .D_instr(D_instr), .D_pc(D_pc), .D_rsData(D_rsData), .D_rtData(D_rtData),
        .D_imm(D_imm), .D_valid(D_valid),
        .E_instr(E_instr), .E_pc(E_pc), .E_rsData(E_rsData), .E_rtData(E_rtData),
        .E_imm(E_imm), .E_rsAddr(E_rsAddr), .E_rtAddr(E_rtAddr), .E_rdAddr(E_rdAddr),
        .E_shamt(E_shamt), .E_valid(E_valid), .E_bubbleCnt(E_bubbleCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit expired, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    function automatic expT withSlices(expT s);
        expT r = s;
        r.rsAddr = s.instr[25:21];
        r.rtAddr = s.instr[20:16];
        r.rdAddr = s.instr[15:11];
        r.shamt  = s.instr[10:6];
        return r;
    endfunction

    function automatic expT resetState();
        expT r = '0;
        r.pc = 32'h0000_3000;
        return withSlices(r);
    endfunction

    function automatic expT applyEdge(expT cur, logic e, logic c, logic [31:0] instr,
                                      logic [31:0] pc, logic [31:0] rs, logic [31:0] rt,
                                      logic [31:0] imm, logic v);
        expT n = cur;
        if (c) begin
            n.instr = '0; n.pc = pc; n.rsData = '0; n.rtData = '0; n.imm = '0; n.valid = 1'b0;
            if (cur.cnt != 16'hFFFF) n.cnt = cur.cnt + 16'd1;
        end else if (e) begin
            n.instr = instr; n.pc = pc; n.rsData = rs; n.rtData = rt; n.imm = imm; n.valid = v;
        end
        return withSlices(n);
    endfunction

    function automatic expT sampleDut();
        expT s;
        s.instr = E_instr; s.pc = E_pc; s.rsData = E_rsData; s.rtData = E_rtData;
        s.imm = E_imm; s.valid = E_valid; s.cnt = E_bubbleCnt;
        s.rsAddr = E_rsAddr; s.rtAddr = E_rtAddr; s.rdAddr = E_rdAddr; s.shamt = E_shamt;
        return s;
    endfunction

    // Drive one edge's inputs, record the expected result, then step past the edge.
    task automatic stepCycle(input logic e, input logic c, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] imm, input logic v);
        en = e; clr = c; D_instr = instr; D_pc = pc; D_rsData = rs; D_rtData = rt;
        D_imm = imm; D_valid = v;
        mdl = applyEdge(mdl, e, c, instr, pc, rs, rt, imm, v);
        sbQ.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        mdl = resetState();
        sbQ.push_back(mdl);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_held: got %h exp %h", got, exp);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        got = sampleDut(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle_edge: got %h exp %h", got, exp);
        end
    endtask

    task automatic test_load();
        stepCycle(1'b1, 1'b0, 32'h3422_ABCD, 32'h0000_3004, 32'h1111_2222, 32'h3333_4444,
                  32'h0000_ABCD, 1'b1);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL load_ori: got %h exp %h", got, exp);
        end
        checks++;
        if (E_rsAddr !== 5'd1 || E_rtAddr !== 5'd2 || E_rdAddr !== 5'd21 || E_shamt !== 5'd15) begin
            failures++;
            $display("FAIL load_slices: got rs=%0d rt=%0d rd=%0d sh=%0d exp rs=1 rt=2 rd=21 sh=15",
                     E_rsAddr, E_rtAddr, E_rdAddr, E_shamt);
        end
    endtask

    task automatic test_sign_imm();
        stepCycle(1'b1, 1'b0, 32'h2109_8000, 32'h0000_3008, 32'hDEAD_BEEF, 32'h0BAD_F00D,
                  32'hFFFF_8000, 1'b1);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL sign_imm: got %h exp %h", got, exp);
        end
        stepCycle(1'b1, 1'b0, 32'h0000_0000, 32'h0000_300C, 32'h0, 32'h0, 32'h0000_7FFF, 1'b0);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL invalid_slot: got %h exp %h", got, exp);
        end
    endtask

    task automatic test_bubble();
        stepCycle(1'b1, 1'b1, 32'h3422_ABCD, 32'h0000_3010, 32'h0000_1234, 32'h5555_AAAA,
                  32'h0000_ABCD, 1'b1);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bubble_first: got %h exp %h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            stepCycle(i[0], 1'b1, 32'hFFFF_FFFF, 32'h0000_3010 + 32'(i), 32'h1, 32'h2, 32'h3, 1'b1);
            got = sampleDut(); exp = sbQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bubble_repeat%0d: got %h exp %h", i, got, exp);
            end
        end
        checks++;
        if (E_bubbleCnt !== 16'd4) begin
            failures++;
            $display("FAIL bubble_count: got %0d exp 4", E_bubbleCnt);
        end
    endtask

    task automatic test_hold();
        stepCycle(1'b1, 1'b0, 32'h0043_2820, 32'h0000_3020, 32'hCAFE_0001, 32'hCAFE_0002,
                  32'h0000_2820, 1'b1);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL hold_preload: got %h exp %h", got, exp);
        end
        for (int i = 0; i < 5; i++) begin
            stepCycle(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom,
                      1'($urandom_range(0, 1)));
            got = sampleDut(); exp = sbQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL hold_cycle%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
            got = sampleDut(); exp = sbQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        reset = 1'b1;
        mdl = resetState();
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 65534; i++) begin
            stepCycle(1'b0, 1'b1, 32'h0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 1'b0);
            void'(sbQ.pop_front());
        end
        checks++;
        if (E_bubbleCnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload: got %h exp fffe", E_bubbleCnt);
        end
        for (int i = 0; i < 3; i++) begin
            stepCycle(1'b1, 1'b1, 32'h1234_5678, 32'h0000_5000 + 32'(i), 32'h9, 32'h9, 32'h9, 1'b1);
            got = sampleDut(); exp = sbQ.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sat_edge%0d: got %h exp %h", i, got, exp);
            end
        end
        #3;
        reset = 1'b1;
        mdl = resetState();
        sbQ.push_back(mdl);
        #1;
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL async_reset: got %h exp %h", got, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        stepCycle(1'b1, 1'b0, 32'h3422_ABCD, 32'h0000_3004, 32'h7, 32'h8, 32'h0000_ABCD, 1'b1);
        got = sampleDut(); exp = sbQ.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL post_reset_load: got %h exp %h", got, exp);
        end
    endtask

    initial begin
        mdl = resetState();
        test_reset();
        test_load();
        test_sign_imm();
        test_bubble();
        test_hold();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/de_pipe_reg.md
# de_pipe_reg

Decode-to-Execute pipeline register of the five-stage MIPS core. It sits directly downstream of the immediate extender and the GRF read ports. It captures the decoded instruction, PC, forwarded register operands and the 32-bit extended immediate each cycle, and presents them to the Execute stage. It supports three behaviours on a clock edge:
- **Load:** normal capture of the Decode-stage values.
- **Hold:** keep the current contents.
- **Bubble insertion:** load a nop, driven by the hazard unit on a load-use or MDU stall.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded into E_pc on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = load D-side inputs on the edge; 0 = hold
- clr  in  1  1 = load a bubble on the edge; overrides en
- D_instr  in  32  instruction word in Decode
- D_pc  in  32  PC of the Decode instruction
- D_rsData  in  32  rs operand after Decode-stage forwarding
- D_rtData  in  32  rt operand after Decode-stage forwarding
- D_imm  in  32  extender output (zero- or sign-extended imm16)
- D_valid  in  1  Decode slot holds a real instruction
- E_instr  out  32  registered instruction
- E_pc  out  32  registered PC
- E_rsData, E_rtData  out  32 each  registered operands
- E_imm  out  32  registered immediate
- E_rsAddr, E_rtAddr, E_rdAddr  out  5 each  E_instr[25:21], [20:16], [15:11]
- E_shamt  out  5  E_instr[10:6]
- E_valid  out  1  Execute slot holds a real instruction
- E_bubbleCnt  out  16  number of bubbles inserted since reset

## Operation
- **Priority, highest first:** reset, then clr, then en, then hold.
- **reset = 1 (asynchronous, effective immediately):**
  - E_instr = 0 (sll $0,$0,0, i.e. nop).
  - E_pc = RESET_PC.
  - E_rsData = E_rtData = E_imm = 0.
  - E_valid = 0.
  - E_bubbleCnt = 0.
- **clr = 1 (bubble):**
  - E_instr, E_rsData, E_rtData and E_imm load 0.
  - E_valid loads 0.
  - E_pc loads D_pc, so the stalled instruction's PC stays traceable.
  - E_bubbleCnt increments by 1. It saturates at 16'hFFFF and does not wrap.
  - en is ignored.
- **clr = 0, en = 1:**
  - Every E_* register loads its D_* counterpart unchanged.
  - E_imm = D_imm bit-exact; no re-extension is performed.
  - E_valid = D_valid.
  - E_bubbleCnt is unchanged.
- **clr = 0, en = 0:** all registers hold, including E_bubbleCnt.
- **Address fields:** E_rsAddr, E_rtAddr, E_rdAddr and E_shamt are combinational slices of the registered E_instr. No extra registers are used for them, so they are always consistent with E_instr.
- **Bubble vs. reset:** a bubble is architecturally a nop. E_rdAddr = 0 and E_rtAddr = 0 guarantee that no GRF write and no forwarding match occur downstream.
- **No storage beyond listed outputs:** the block has no internal state beyond the registers that drive the listed outputs.

## Timing
- **Latency:** one cycle. A value presented on D_* before edge n appears on E_* after edge n.
- **Stall interaction:** the hazard unit asserts clr on this block in the same cycle it deasserts en on the F/D register and PC. The stalled instruction therefore re-enters next cycle and a bubble occupies Execute.
- **Consecutive clr:** one bubble per edge; E_bubbleCnt increases by one per edge.
- **clr and en both high:** treated exactly as clr alone.
- **Reset asserted mid-cycle:** outputs change to reset values without waiting for clk. After reset deasserts, the first rising edge performs a normal clr/en evaluation.
- **Reset released coincident with a clock edge:** that edge is ignored. The next edge is the first capture.
- **Glitch-free outputs:** all outputs are glitch-free registered values, apart from the address/shamt slices, which are pure wiring of E_instr.

## Test plan
- **Reset:** assert reset between edges → E_pc = 32'h0000_3000, E_instr = 0, E_valid = 0, E_bubbleCnt = 0 immediately, before the next edge.
- **Normal load:** en = 1, clr = 0, D_instr = 32'h3422_ABCD (ori), D_imm = 32'h0000_ABCD, D_pc = 32'h3004, D_valid = 1 → after one edge E_imm = 32'h0000_ABCD, E_rsAddr = 1, E_rtAddr = 2, E_pc = 32'h3004, E_valid = 1.
- **Sign-extended immediate:** D_imm = 32'hFFFF_8000 → E_imm = 32'hFFFF_8000 after one edge.
- **Bubble:** clr = 1 with en = 1, D_pc = 32'h3010, D_rsData = 32'h1234 → E_instr = 0, E_rsData = 0, E_valid = 0, E_pc = 32'h3010, E_bubbleCnt += 1. Then three more clr cycles → count = 4.
- **Hold:** en = 0, clr = 0 for 5 cycles while the D_* inputs toggle randomly → all E_* outputs stay constant.
- **Saturation and async reset:** preload counter to 16'hFFFE, apply 3 clr edges → count = 16'hFFFF. Then assert reset mid-cycle → count = 0 and outputs at reset values without a clock edge.
